// File: rtl/nibble_serial_adder.sv
// Nibble-serial add/subtract sequencer driving an external combinational 4-bit adder.
// Optional `zero` result flag is enabled by defining NIBBLE_SERIAL_ADDER_ZERO_EN.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow
`ifdef NIBBLE_SERIAL_ADDER_ZERO_EN
  ,
  output logic                 zero
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry_r;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          load;
  logic          last;
  logic          fin;

  // A request is taken in IDLE and also on the edge that leaves DONE.
  assign load = start && (state == S_IDLE || state == S_DONE);
  assign last = (idx == IW'(NIBBLES - 1));
  assign fin  = (state == S_RUN) && last;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = a_reg[4*idx +: 4];
      add_b   = b_reg[4*idx +: 4];
      add_cin = carry_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_r   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load) begin
            a_reg   <= op_a;
            b_reg   <= sub ? ~op_b : op_b;
            carry_r <= sub;
            idx     <= '0;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          result[4*idx +: 4] <= add_s;
          carry_r            <= add_cout;
          if (last) begin
            state     <= S_DONE;
            carry_out <= add_cout;
            // The top nibble's sum is not in `result` yet, so use add_s directly.
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_ZERO_EN
  logic nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz   <= 1'b0;
      zero <= 1'b0;
    end else if (load) begin
      nz <= 1'b0;
    end else if (state == S_RUN) begin
      nz <= nz | (add_s != 4'd0);
      if (fin) zero <= !(nz | (add_s != 4'd0));
    end
  end
`endif

endmodule
